// File: rtl/mult_8x8_seq_ctrl_if.sv
// Request/response handshake bundle for the 8x8 sequenced multiplier.
// The requester owns the master modport; the multiplier owns the slave modport.
interface mult_8x8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] R;

    modport master (
        output in_valid, A, B, mode, out_ready,
        input  in_ready, out_valid, R
    );

    modport slave (
        input  in_valid, A, B, mode, out_ready,
        output in_ready, out_valid, R
    );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// Time-shares one external 4x4 (approximate) multiplier core over four steps
// to build an 8x8 product, merged by shifted add or by OR-combine.
module mult_8x8_seq_ctrl #(
    parameter bit COMBINE   = 1'b0,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mult_8x8_seq_ctrl_if.slave        bus,
    output logic [3:0]                pp_a,
    output logic [3:0]                pp_b,
    output logic [1:0]                pp_sel,
    input  logic [7:0]                pp_r
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [7:0]  a_q, b_q, mode_q;
    logic [15:0] acc, acc_nxt, pp_shifted, r_q;
    logic        accept, zero_op;

    assign accept  = bus.in_valid && (state == IDLE);
    assign zero_op = ZERO_SKIP && ((bus.A == 8'd0) || (bus.B == 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = zero_op ? DONE : CALC;
            CALC:    if (step == 2'd3) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Step order AL*BL, AL*BH, AH*BL, AH*BH: step[1] picks the A nibble, step[0] the B nibble.
    always_comb begin
        pp_a       = 4'd0;
        pp_b       = 4'd0;
        pp_sel     = 2'd0;
        pp_shifted = 16'd0;
        if (state == CALC) begin
            pp_a   = step[1] ? a_q[7:4] : a_q[3:0];
            pp_b   = step[0] ? b_q[7:4] : b_q[3:0];
            pp_sel = mode_q[{step, 1'b0} +: 2];
            case (step)
                2'd0:    pp_shifted = {8'h00, pp_r};
                2'd3:    pp_shifted = {pp_r, 8'h00};
                default: pp_shifted = {4'h0, pp_r, 4'h0};
            endcase
        end
    end

    // Carries past bit 15 from approximate partial products are dropped.
    assign acc_nxt = COMBINE ? (acc | pp_shifted) : (acc + pp_shifted);

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= 2'd0;
            acc    <= 16'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            mode_q <= 8'd0;
            r_q    <= 16'd0;
        end else if (accept) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            mode_q <= bus.mode;
            acc    <= 16'd0;
            step   <= 2'd0;
            if (zero_op) r_q <= 16'd0;
        end else if (state == CALC) begin
            acc  <= acc_nxt;
            step <= step + 2'd1;
            if (step == 2'd3) r_q <= acc_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.R         = r_q;
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench for mult_8x8_seq_ctrl: one add-merge and one OR-merge instance,
// behavioural 4x4 core variants, and a result scoreboard filled at accept time.
module tb_mult_8x8_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_8x8_seq_ctrl_if bus0 ();
    mult_8x8_seq_ctrl_if bus1 ();

    logic [3:0] pp_a0, pp_b0, pp_a1, pp_b1;
    logic [1:0] pp_sel0, pp_sel1;
    logic [7:0] pp_r0, pp_r1;

    // Core variants: exact, N1 drops bit 0, N2 drops bits 1:0, R2 rounds to a multiple of 4.
    function automatic logic [7:0] core_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] sel);
        logic [7:0] p;
        p = {4'h0, a} * {4'h0, b};
        case (sel)
            2'd0:    return p;
            2'd1:    return p & 8'hFE;
            2'd2:    return p & 8'hFC;
            default: return (p + 8'd2) & 8'hFC;
        endcase
    endfunction

    always_comb pp_r0 = core_fn(pp_a0, pp_b0, pp_sel0);
    always_comb pp_r1 = core_fn(pp_a1, pp_b1, pp_sel1);

    mult_8x8_seq_ctrl #(.COMBINE(1'b0), .ZERO_SKIP(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .pp_a(pp_a0), .pp_b(pp_b0), .pp_sel(pp_sel0), .pp_r(pp_r0)
    );

    mult_8x8_seq_ctrl #(.COMBINE(1'b1), .ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .pp_a(pp_a1), .pp_b(pp_b1), .pp_sel(pp_sel1), .pp_r(pp_r1)
    );

    // Requester side: one stimulus set, steered to the instance chosen by sel.
    logic       sel;
    logic       req_valid, req_out_ready;
    logic [7:0] req_a, req_b, req_mode;

    assign bus0.in_valid  = req_valid && !sel;
    assign bus1.in_valid  = req_valid && sel;
    assign bus0.A         = req_a;
    assign bus1.A         = req_a;
    assign bus0.B         = req_b;
    assign bus1.B         = req_b;
    assign bus0.mode      = req_mode;
    assign bus1.mode      = req_mode;
    assign bus0.out_ready = req_out_ready;
    assign bus1.out_ready = req_out_ready;

    logic        obs_ir, obs_ov;
    logic [15:0] obs_r;
    logic [3:0]  obs_pa, obs_pb;
    logic [1:0]  obs_ps;

    always_comb begin
        obs_ir = sel ? bus1.in_ready  : bus0.in_ready;
        obs_ov = sel ? bus1.out_valid : bus0.out_valid;
        obs_r  = sel ? bus1.R         : bus0.R;
        obs_pa = sel ? pp_a1          : pp_a0;
        obs_pb = sel ? pp_b1          : pp_b0;
        obs_ps = sel ? pp_sel1        : pp_sel0;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] m, input bit comb);
        logic [15:0] acc, t;
        logic [3:0]  na, nb;
        acc = 16'd0;
        if (a == 8'd0 || b == 8'd0) return 16'd0;
        for (int s = 0; s < 4; s++) begin
            na = (s >= 2) ? a[7:4] : a[3:0];
            nb = (s == 1 || s == 3) ? b[7:4] : b[3:0];
            t  = {8'h00, core_fn(na, nb, m[2*s +: 2])};
            t  = t << ((s == 0) ? 0 : (s == 3) ? 8 : 4);
            acc = comb ? (acc | t) : (acc + t);
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!obs_ir && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!obs_ir) check("ready_timeout", {31'd0, obs_ir}, 32'd1);
    endtask

    // One request: checks the step table each cycle, latency, result, and optional backpressure.
    task automatic do_txn(input bit c, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] m, input int bp);
        logic [15:0] r_exp;
        bit          zero;
        sel  = c;
        zero = (a == 8'd0) || (b == 8'd0);
        @(negedge clk);
        wait_ready();
        req_a = a; req_b = b; req_mode = m; req_valid = 1'b1;
        req_out_ready = (bp == 0);
        exp_q.push_back(model(a, b, m, c));
        @(negedge clk);
        // Scramble inputs after accept; the latched copy must be used.
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_mode = ~m;
        if (zero) begin
            check("zskip_valid", {31'd0, obs_ov}, 32'd1);
            check("zskip_pp_a", {28'd0, obs_pa}, 32'd0);
            check("zskip_pp_b", {28'd0, obs_pb}, 32'd0);
        end else begin
            for (int s = 0; s < 4; s++) begin
                check("pp_a", {28'd0, obs_pa}, {28'd0, (s >= 2) ? a[7:4] : a[3:0]});
                check("pp_b", {28'd0, obs_pb}, {28'd0, (s == 1 || s == 3) ? b[7:4] : b[3:0]});
                check("pp_sel", {30'd0, obs_ps}, {30'd0, m[2*s +: 2]});
                check("calc_no_valid", {31'd0, obs_ov}, 32'd0);
                @(negedge clk);
            end
            check("latency_valid", {31'd0, obs_ov}, 32'd1);
            check("done_pp_a", {28'd0, obs_pa}, 32'd0);
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            r_exp = 16'd0;
        end else begin
            r_exp = exp_q.pop_front();
            check("result", {16'd0, obs_r}, {16'd0, r_exp});
        end
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", {31'd0, obs_ov}, 32'd1);
            check("bp_r", {16'd0, obs_r}, {16'd0, r_exp});
            check("bp_in_ready", {31'd0, obs_ir}, 32'd0);
        end
        if (bp > 0) begin
            req_valid = 1'b0;
            req_out_ready = 1'b1;
            @(negedge clk);
            check("hs_valid_low", {31'd0, obs_ov}, 32'd0);
            check("hs_in_ready", {31'd0, obs_ir}, 32'd1);
            check("hs_r_keep", {16'd0, obs_r}, {16'd0, r_exp});
        end
    endtask

    initial begin
        sel = 1'b0; req_valid = 1'b0; req_out_ready = 1'b1;
        req_a = 8'd0; req_b = 8'd0; req_mode = 8'd0;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            sel = c[0];
            #1;
            check("rst_in_ready", {31'd0, obs_ir}, 32'd1);
            check("rst_out_valid", {31'd0, obs_ov}, 32'd0);
            check("rst_r", {16'd0, obs_r}, 32'd0);
            check("rst_pp_a", {28'd0, obs_pa}, 32'd0);
            check("rst_pp_sel", {30'd0, obs_ps}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(1'b0, 8'h12, 8'h34, 8'h00, 0);
        do_txn(1'b0, 8'hFF, 8'hFF, 8'h00, 0);
        do_txn(1'b0, 8'h80, 8'h02, 8'h00, 0);
        do_txn(1'b1, 8'h11, 8'h11, 8'h00, 0);
        do_txn(1'b0, 8'h11, 8'h11, 8'h00, 0);
        do_txn(1'b0, 8'hA7, 8'h5C, 8'hE4, 0);
        do_txn(1'b1, 8'hA7, 8'h5C, 8'hE4, 0);
        do_txn(1'b0, 8'hFF, 8'hEE, 8'hFF, 0);
        do_txn(1'b0, 8'h00, 8'h55, 8'h00, 0);
        do_txn(1'b1, 8'h3C, 8'h00, 8'hFF, 0);
        do_txn(1'b0, 8'hC9, 8'h7E, 8'h39, 3);

        // Reset pulse during step 2 aborts the transaction.
        sel = 1'b0;
        @(negedge clk);
        wait_ready();
        req_a = 8'h5A; req_b = 8'hC3; req_mode = 8'h1B; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("s2_pp_a", {28'd0, obs_pa}, 32'h5);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, obs_ov}, 32'd0);
        check("abort_in_ready", {31'd0, obs_ir}, 32'd1);
        check("abort_pp_a", {28'd0, obs_pa}, 32'd0);
        check("abort_pp_b", {28'd0, obs_pb}, 32'd0);
        check("abort_pp_sel", {30'd0, obs_ps}, 32'd0);
        check("abort_r", {16'd0, obs_r}, 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_abort_no_valid", {31'd0, obs_ov}, 32'd0);
        end
        do_txn(1'b0, 8'h12, 8'h34, 8'h00, 0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
